// File: rtl/kfpga_config_controller.sv
// Configuration loader for the kfpga fabric: it accepts N data words and a trailing XOR checksum word,
// and commits the shadow image to config_out and releases the fabric reset only when the checksum matches.
module kfpga_config_controller #(
  parameter int CONFIG_WIDTH = 1602,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    cfg_start,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    core_nreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  // Counter value at which the next accepted word is the checksum rather than data.
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        word_cnt;
  logic [WORD_WIDTH-1:0]   run_xor;
  logic [WORD_WIDTH-1:0]   csum_word;
  logic                    match_q;
  logic                    verify_phase;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CONFIG_WIDTH-1:0] shadow_next;
  logic                    xfer;

  assign xfer = cfg_valid && cfg_ready;

  // Each shadow bit belongs to exactly one word slot; bits of the last word that lie above
  // CONFIG_WIDTH-1 have no slot, so they are dropped here while still feeding run_xor.
  always_comb begin
    // NOTE: default assignment first so every path writes shadow_next and no latch is inferred.
    shadow_next = shadow;
    for (int i = 0; i < CONFIG_WIDTH; i++) begin
      if ((i / WORD_WIDTH) == int'(word_cnt)) begin
        shadow_next[i] = cfg_data[i % WORD_WIDTH];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      run_xor      <= '0;
      csum_word    <= '0;
      match_q      <= 1'b0;
      verify_phase <= 1'b0;
      // NOTE: the wide shadow and config registers are reset on purpose; the fabric must see all-zero config.
      shadow       <= '0;
      config_out   <= '0;
      core_nreset  <= 1'b0;
      cfg_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (cfg_start) begin
            state       <= S_LOAD;
            word_cnt    <= '0;
            run_xor     <= '0;
            core_nreset <= 1'b0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
          end
        end

        S_LOAD: begin
          if (cfg_start) begin
            // Restart wins over a transfer in the same cycle.
            word_cnt <= '0;
            run_xor  <= '0;
          end else if (xfer) begin
            if (word_cnt == CSUM_IDX) begin
              csum_word    <= cfg_data;
              verify_phase <= 1'b0;
              cfg_ready    <= 1'b0;
              state        <= S_VERIFY;
            end else begin
              shadow   <= shadow_next;
              run_xor  <= run_xor ^ cfg_data;
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        S_VERIFY: begin
          // Compare in the first cycle and act in the second, so the wide compare is kept out of the commit path.
          if (!verify_phase) begin
            match_q      <= (csum_word == run_xor);
            verify_phase <= 1'b1;
          end else begin
            busy <= 1'b0;
            if (match_q) begin
              config_out  <= shadow;
              core_nreset <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          core_nreset <= 1'b0;
          cfg_ready   <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          error       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kfpga_config_controller.sv
// Directed bench for kfpga_config_controller at CONFIG_WIDTH=40, WORD_WIDTH=16 (three data words plus checksum).
module tb_kfpga_config_controller;

  localparam int CW = 40;
  localparam int WW = 16;
  localparam logic [CW-1:0] CFG_A = 40'hFF_ABCD_1234;
  localparam logic [CW-1:0] CFG_B = 40'h03_0002_0001;

  logic          clock = 1'b0;
  logic          nreset;
  logic          cfg_start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] config_out;
  logic          core_nreset;
  logic          busy;
  logic          done;
  logic          error;

  int vectors     = 0;
  int miscompares = 0;

  kfpga_config_controller #(
    .CONFIG_WIDTH (CW),
    .WORD_WIDTH   (WW)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .cfg_start   (cfg_start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .config_out  (config_out),
    .core_nreset (core_nreset),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg"},   64'(config_out), 64'h0);
    check({tag, "_core"},  64'(core_nreset), 64'h0);
    check({tag, "_ready"}, 64'(cfg_ready), 64'h0);
    check({tag, "_busy"},  64'(busy), 64'h0);
    check({tag, "_done"},  64'(done), 64'h0);
    check({tag, "_error"}, 64'(error), 64'h0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input int gap);
    int n = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'(cfg_ready), 64'h1);
    @(negedge clock);
    cfg_valid = 1'b0;
    cfg_data  = 16'hxxxx;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] w2, input logic [WW-1:0] cs, input int gap);
    pulse_start();
    send_word(w0, gap);
    send_word(w1, gap);
    send_word(w2, gap);
    send_word(cs, 0);
  endtask

  // Entered at the negedge right after the checksum edge; the result must appear after two edges.
  task automatic expect_result(input string tag, input bit ok, input logic [CW-1:0] cfg, input bit poke_start);
    check({tag, "_ready_after_cs"}, 64'(cfg_ready), 64'h0);
    check({tag, "_busy_v0"},        64'(busy), 64'h1);
    check({tag, "_done_v0"},        64'(done), 64'h0);
    if (poke_start) cfg_start = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    check({tag, "_busy_v1"}, 64'(busy), 64'h1);
    check({tag, "_done_v1"}, 64'(done), 64'h0);
    @(negedge clock);
    check({tag, "_busy"},  64'(busy), 64'h0);
    check({tag, "_done"},  64'(done), 64'(ok));
    check({tag, "_error"}, 64'(error), 64'(!ok));
    check({tag, "_core"},  64'(core_nreset), 64'(ok));
    check({tag, "_cfg"},   64'(config_out), 64'(cfg));
    check({tag, "_ready"}, 64'(cfg_ready), 64'h0);
  endtask

  initial begin
    nreset    = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    nreset = 1'b1;

    // Stays idle, fabric held, even with cfg_valid toggling.
    cfg_valid = 1'b1;
    cfg_data  = 16'h5A5A;
    repeat (3) @(negedge clock);
    cfg_valid = 1'b0;
    check_all_zero("idle");

    // Bad checksum straight after reset: error, config_out stays 0.
    pulse_start();
    check("load_ready", 64'(cfg_ready), 64'h1);
    check("load_busy",  64'(busy), 64'h1);
    check("load_core",  64'(core_nreset), 64'h0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h00FF, 0);
    send_word(16'hB907, 0);
    expect_result("bad_after_reset", 1'b0, '0, 1'b0);

    // Good load from ERROR.
    send_load(16'h1234, 16'hABCD, 16'h00FF, 16'hB906, 0);
    expect_result("good", 1'b1, CFG_A, 1'b0);

    // Bad load from DONE: fabric back in reset from the first LOAD cycle, config_out kept.
    pulse_start();
    check("from_done_core", 64'(core_nreset), 64'h0);
    check("from_done_done", 64'(done), 64'h0);
    check("from_done_cfg",  64'(config_out), 64'(CFG_A));
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h00FF, 0);
    send_word(16'hB907, 0);
    expect_result("bad_from_done", 1'b0, CFG_A, 1'b0);

    // Last word upper byte discarded from config but still in the checksum.
    send_load(16'h0001, 16'h0002, 16'hA503, 16'hA500, 0);
    expect_result("trunc", 1'b1, CFG_B, 1'b0);

    // Stalls of 1 and 5 cycles; cfg_start during VERIFY is ignored.
    send_load(16'h1234, 16'hABCD, 16'h00FF, 16'hB906, 1);
    expect_result("gap1", 1'b1, CFG_A, 1'b1);
    send_load(16'h0001, 16'h0002, 16'hA503, 16'hA500, 5);
    expect_result("gap5", 1'b1, CFG_B, 1'b0);

    // Restart after two words; a transfer in the restart cycle is discarded.
    pulse_start();
    send_word(16'h5555, 0);
    send_word(16'h6666, 0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'hDEAD;
    @(negedge clock);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("restart_ready", 64'(cfg_ready), 64'h1);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h00FF, 0);
    send_word(16'hB906, 0);
    expect_result("restart", 1'b1, CFG_A, 1'b0);

    // Asynchronous reset mid-load from DONE, then a full load.
    pulse_start();
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    nreset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);
    check_all_zero("post_rst_idle");
    send_load(16'h1234, 16'hABCD, 16'h00FF, 16'hB906, 0);
    expect_result("after_rst", 1'b1, CFG_A, 1'b0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
